// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial add/sub arbiter: FSM encoding and slice geometry.
package nibble_add_pkg;

    localparam int NIBBLES_DEFAULT = 4;
    localparam int NIB_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca4.sv
// Combinational 4-bit ripple-carry slice; the only adder on the operand path.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_add_arbiter.sv
// Two-requester round-robin arbiter feeding a nibble-serial adder/subtractor built on one shared rca4 slice.
module nibble_add_arbiter
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_sub,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_sub,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_id,
    output logic [4*NIBBLES-1:0]   res_sum,
    output logic                   res_cout,
    output logic                   res_ovf
);

    localparam int DATA_W = NIB_W * NIBBLES;
    localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    state_t                     state_q, state_d;
    logic                       gnt_id;
    logic                       accept;
    logic                       last_nib;

    logic signed [DATA_W-1:0]   a_p0, b_p0;
    logic                       carry_p0;
    logic [IDX_W-1:0]           idx_p0;
    logic                       prio_p0;

    logic signed [DATA_W-1:0]   sum_p1;
    logic                       cout_p1, ovf_p1, id_p1;

    logic [IDX_W+1:0]           nib_sh;
    logic [NIB_W-1:0]           slice_a, slice_b, slice_s;
    logic                       slice_c;

    // Arbitration and next-state: prio_p0 names the requester favoured on a tie.
    always_comb begin
        state_d    = state_q;
        gnt_id     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = prio_p0;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    req0_ready = req0_valid && !gnt_id;
                    req1_ready = req1_valid &&  gnt_id;
                    if (req0_ready || req1_ready) state_d = RUN;
                end
            end
            RUN:     if (last_nib) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reset) state_d = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign accept   = req0_ready || req1_ready;
    assign last_nib = (idx_p0 == IDX_LAST);
    assign nib_sh   = {idx_p0, 2'b00};
    assign slice_a  = a_p0[nib_sh +: NIB_W];
    assign slice_b  = b_p0[nib_sh +: NIB_W];

    rca4 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_p0),
        .s    (slice_s),
        .cout (slice_c)
    );

    // Stage p0: operand capture, subtrahend already inverted so the slice only ever adds.
    always_ff @(posedge clock) begin
        if (accept) begin
            a_p0 <= gnt_id ? req1_a : req0_a;
            if (gnt_id) b_p0 <= req1_sub ? ~req1_b : req1_b;
            else        b_p0 <= req0_sub ? ~req0_b : req0_b;
        end
    end

    // Stage p1: one nibble of result per RUN edge; flags taken from the final slice.
    always_ff @(posedge clock) begin
        if (reset) begin
            carry_p0 <= 1'b0;
            idx_p0   <= '0;
            prio_p0  <= 1'b0;
            sum_p1   <= '0;
            cout_p1  <= 1'b0;
            ovf_p1   <= 1'b0;
            id_p1    <= 1'b0;
        end else if (accept) begin
            carry_p0 <= gnt_id ? req1_sub : req0_sub;
            idx_p0   <= '0;
            prio_p0  <= ~gnt_id;
            id_p1    <= gnt_id;
        end else if (state_q == RUN) begin
            sum_p1[nib_sh +: NIB_W] <= slice_s;
            carry_p0 <= slice_c;
            idx_p0   <= idx_p0 + 1'b1;
            if (last_nib) begin
                cout_p1 <= slice_c;
                ovf_p1  <= signed_ovf(a_p0[DATA_W-1], b_p0[DATA_W-1], slice_s[NIB_W-1]);
            end
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_id    = id_p1;
    assign res_sum   = sum_p1;
    assign res_cout  = cout_p1;
    assign res_ovf   = ovf_p1;

endmodule

// File: tb/tb_nibble_add_arbiter.sv
// Directed-vector bench for nibble_add_arbiter with hand-computed expected results.
module tb_nibble_add_arbiter;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req0_sub;
    logic [W-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_sub;
    logic [W-1:0]  req1_a, req1_b;
    logic          res_valid, res_ready, res_id, res_cout, res_ovf;
    logic [W-1:0]  res_sum;

    int nvec = 0;
    int nmis = 0;

    nibble_add_arbiter #(.NIBBLES(NIBBLES)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_ovf    (res_ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                          input logic [W-1:0] esum, input bit ecout, input bit eovf, input int hold);
        int cnt;
        @(negedge clock);
        if (!id) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end
        #1;
        chk("ready_granted", id ? req1_ready : req0_ready, 1);
        chk("ready_other",   id ? req0_ready : req1_ready, 0);
        @(posedge clock);
        @(negedge clock);
        // Scramble the request side after acceptance.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req0_sub = ~sub;
        req1_a = ~a; req1_b = ~b; req1_sub = ~sub;
        cnt = 0;
        while (!res_valid && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        chk("latency", cnt, NIBBLES);
        chk("sum",  res_sum,  esum);
        chk("cout", res_cout, ecout);
        chk("ovf",  res_ovf,  eovf);
        chk("id",   res_id,   id);
        for (int k = 0; k < hold; k++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            chk("hold_r0",    req0_ready, 0);
            chk("hold_r1",    req1_ready, 0);
            chk("hold_valid", res_valid,  1);
            chk("hold_sum",   res_sum,    esum);
            chk("hold_flags", {res_cout, res_ovf, res_id}, {ecout, eovf, id});
            @(negedge clock);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        res_ready = 1'b0;
        #1;
        chk("drained_valid", res_valid, 0);
        chk("id_kept",       res_id,    id);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_r0", req0_ready, 0);
        chk("rst_r1", req1_ready, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("rst_valid", res_valid, 0);
        chk("rst_sum",   res_sum,   0);
        chk("rst_flags", {res_cout, res_ovf, res_id}, 3'b000);
    endtask

    initial begin
        int gid[4];
        int gcyc[4];
        int ng;

        reset = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        repeat (2) @(posedge clock);
        pulse_reset();

        run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
        run_op(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op(1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 0);
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 10);
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op(1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);

        // Round-robin with both requesters permanently valid.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin gid[i] = -1; gcyc[i] = -1; end
        ng = 0;
        req0_a = 16'h0101; req0_b = 16'h0202; req0_sub = 1'b0;
        req1_a = 16'h0303; req1_b = 16'h0101; req1_sub = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        #1;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            if (req0_ready || req1_ready) begin
                gid[ng]  = req1_ready ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
            @(negedge clock);
            #1;
        end
        chk("tie_grants", ng, 4);
        chk("tie_g0", gid[0], 0);
        chk("tie_g1", gid[1], 1);
        chk("tie_g2", gid[2], 0);
        chk("tie_g3", gid[3], 1);
        for (int i = 1; i < 4; i++) chk("tie_spacing", gcyc[i] - gcyc[i-1], NIBBLES + 2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (8) @(negedge clock);
        res_ready = 1'b0;

        // Reset after two RUN nibbles while the tie pointer favours requester 1.
        run_op(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 0);
        @(negedge clock);
        req0_valid = 1'b1; req0_a = 16'h4444; req0_b = 16'h1111; req0_sub = 1'b0;
        #1;
        chk("mid_accept_r0", req0_ready, 1);
        @(posedge clock);
        @(negedge clock);
        req0_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_sum",   res_sum,   0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("post_rst_tie_r0", req0_ready, 1);
        chk("post_rst_tie_r1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(negedge clock);
        chk("no_stale_result", res_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/nibble_add_arbiter.md
NIBBLE_ADD_ARBITER -- requirements
Module: nibble_add_arbiter

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operation; operand width W = 4*NIBBLES (16 at default).
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  in  W  requester 0 operands.
REQ-007 req0_sub  in  1  requester 0 operation select: 1 = a-b, 0 = a+b.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as REQ-004..007 for requester 1.
REQ-009 res_valid  out  1  result available.
REQ-010 res_ready  in  1  result consumer accepts.
REQ-011 res_id  out  1  index of the requester that owns the result.
REQ-012 res_sum  out  W  sum or difference, modulo 2^W.
REQ-013 res_cout  out  1  carry out of the MSB (for sub: 1 = no borrow).
REQ-014 res_ovf  out  1  two's-complement signed overflow.

Function
REQ-015 FSM SHALL have states IDLE, RUN, DONE.
REQ-016 In IDLE, with exactly one reqN_valid high, that requester SHALL be granted.
REQ-017 With both valid high, the requester not served last SHALL be granted (round-robin); after reset, requester 0 wins the first tie.
REQ-018 reqN_ready SHALL be high only in IDLE, only for the granted requester, and only combinationally with its reqN_valid; it SHALL be low in RUN and DONE.
REQ-019 On the accepting edge, the block SHALL capture a and b (b inverted if sub), set carry = sub, record the owner id, clear the nibble index, and enter RUN.
REQ-020 In RUN, each edge SHALL add nibble[index] of a and effective b plus the registered carry through one shared 4-bit slice, write 4 bits of res_sum, register the carry, and increment the index.
REQ-021 After the edge that processes nibble NIBBLES-1, the FSM SHALL enter DONE; res_valid SHALL assert exactly NIBBLES edges after the accepting edge.
REQ-022 In DONE, res_valid = 1 and res_sum/res_cout/res_ovf/res_id SHALL stay stable until res_ready is sampled high; that edge returns to IDLE.
REQ-023 The block SHALL NOT accept a new request in the DONE cycle in which res_ready is high; minimum spacing between accepts is NIBBLES+2 cycles.
REQ-024 res_ovf SHALL be 1 iff a[W-1] equals the effective b[W-1] and res_sum[W-1] differs from them.
REQ-025 Changes to the req inputs after acceptance SHALL NOT affect the result in progress.
REQ-026 While res_valid is low, res_sum, res_cout and res_ovf are don't-care; res_id holds the last owner.

Reset
REQ-027 When reset is high at an edge: FSM → IDLE, res_valid = 0, res_sum = 0, res_cout = 0, res_ovf = 0, res_id = 0, index = 0, carry = 0, round-robin pointer favours requester 0.
REQ-028 Reset mid-RUN or in DONE SHALL discard the operation with no result; it SHALL take priority over every other event in that cycle.
REQ-029 reqN_ready SHALL be 0 while reset is high.

Structure
REQ-030 A shared package nibble_add_pkg SHALL hold the FSM state encoding constants and the NIBBLES default.
REQ-031 One sub-module rca4 SHALL be used: a combinational 4-bit ripple-carry slice (a[3:0], b[3:0], cin → s[3:0], cout), instantiated exactly once.
REQ-032 No other adder SHALL be inferred on the operand path; the index counter is the only other arithmetic.

Verification
REQ-033 req0 add a=0x1234 b=0x0FFF → res_valid 4 edges after accept, res_sum=0x2233, res_cout=0, res_ovf=0, res_id=0.
REQ-034 req1 sub a=0x0005 b=0x0007 → res_sum=0xFFFE, res_cout=0, res_ovf=0, res_id=1; sub a=0x0007 b=0x0005 → 0x0002, res_cout=1.
REQ-035 add 0x7FFF+0x0001 → 0x8000, res_ovf=1, res_cout=0; add 0xFFFF+0x0001 → 0x0000, res_cout=1, res_ovf=0.
REQ-036 Both valid held high, res_ready=1 throughout → grant order 0,1,0,1; accepts exactly NIBBLES+2 cycles apart.
REQ-037 res_ready held low 10 cycles in DONE → res_valid and all result fields stable; both reqN_ready stay 0.
REQ-038 reset pulsed after 2 RUN nibbles → next cycle state IDLE, res_valid=0; a subsequent tie is granted to requester 0.
